// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl: iterative DES round-key sequencer.
// Holds one C/D rotation register pair and a single PC2 network, and
// steps through K1..K16 (encrypt) or K16..K1 (decrypt), presenting one
// 48-bit subkey per round under a valid/accept handshake.
// Optional build macro DES_KEY_SCHED_CHECK_EN adds a SCHED_ERR output
// that flags a C/D end-of-schedule value that does not match the key
// loaded at START.

module des_key_sched_ctrl #(
  parameter bit AUTO_ACCEPT = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET_BAR,
  input  logic        START,
  input  logic        DECRYPT,
  input  logic        ABORT,
  input  logic [28:1] KEY_LEFT,
  input  logic [28:1] KEY_RIGHT,
  input  logic        SUBKEY_ACCEPT,
  output logic [47:0] SUBKEY,
  output logic        SUBKEY_VALID,
  output logic [3:0]  ROUND,
  output logic        BUSY,
  output logic        DONE
`ifdef DES_KEY_SCHED_CHECK_EN
  ,
  output logic        SCHED_ERR
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // PC2 selection, listed as DES bit numbers (bit 1 = first bit of C)
  localparam logic [5:0] PC2_TABLE [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  state_t      state_q, state_d;
  logic [28:1] c_q, c_d;
  logic [28:1] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        dir_q, dir_d;
  logic        startAccepted;
  logic [55:0] cd;

  function automatic logic [28:1] rotl1(input logic [28:1] x);
    return {x[27:1], x[28]};
  endfunction

  function automatic logic [28:1] rotr1(input logic [28:1] x);
    return {x[1], x[28:2]};
  endfunction

  // DES bit n of the 56-bit C||D value lives at cd[56-n]
  assign cd = {c_q, d_q};

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign SUBKEY[6'(47 - g)] = cd[6'(56 - PC2_TABLE[g])];
  end

  assign ROUND         = round_q;
  assign BUSY          = (state_q != IDLE);
  assign startAccepted = (state_q == IDLE) && START && !ABORT;

  // Sequencer next-state: load on START, rotate C/D on each completed handshake
  always_comb begin
    logic oneBit;
    state_d      = state_q;
    c_d          = c_q;
    d_d          = d_q;
    round_d      = round_q;
    dir_d        = dir_q;
    SUBKEY_VALID = 1'b0;
    DONE         = 1'b0;
    oneBit       = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);

    case (state_q)
      IDLE: begin
        if (startAccepted) begin
          dir_d   = DECRYPT;
          c_d     = DECRYPT ? KEY_LEFT  : rotl1(KEY_LEFT);
          d_d     = DECRYPT ? KEY_RIGHT : rotl1(KEY_RIGHT);
          round_d = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ABORT) begin
          state_d = IDLE;
        end else begin
          SUBKEY_VALID = 1'b1;
          if (SUBKEY_ACCEPT || AUTO_ACCEPT) begin
            if (round_q == 4'd15) begin
              state_d = FIN;
            end else begin
              round_d = round_q + 4'd1;
              if (dir_q) begin
                c_d = oneBit ? rotr1(c_q) : rotr1(rotr1(c_q));
                d_d = oneBit ? rotr1(d_q) : rotr1(rotr1(d_q));
              end else begin
                c_d = oneBit ? rotl1(c_q) : rotl1(rotl1(c_q));
                d_d = oneBit ? rotl1(d_q) : rotl1(rotl1(d_q));
              end
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!ABORT) begin
          DONE = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state, C/D pair, round counter and direction registers
  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dir_q   <= dir_d;
    end
  end

`ifdef DES_KEY_SCHED_CHECK_EN
  logic [28:1] keyLeftShadow_q, keyLeftShadow_d;
  logic [28:1] keyRightShadow_q, keyRightShadow_d;
  logic        schedErr_q, schedErr_d;

  assign SCHED_ERR = schedErr_q;

  // Shadow the loaded key and compare the final C/D at FIN; error is sticky
  always_comb begin
    logic [28:1] expC;
    logic [28:1] expD;
    keyLeftShadow_d  = keyLeftShadow_q;
    keyRightShadow_d = keyRightShadow_q;
    schedErr_d       = schedErr_q;
    expC             = dir_q ? rotl1(keyLeftShadow_q)  : keyLeftShadow_q;
    expD             = dir_q ? rotl1(keyRightShadow_q) : keyRightShadow_q;
    if (startAccepted) begin
      keyLeftShadow_d  = KEY_LEFT;
      keyRightShadow_d = KEY_RIGHT;
      schedErr_d       = 1'b0;
    end else if ((state_q == FIN) && !ABORT) begin
      if ((c_q != expC) || (d_q != expD)) begin
        schedErr_d = 1'b1;
      end
    end
  end

  // Shadow key copies and sticky schedule error flag
  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      keyLeftShadow_q  <= '0;
      keyRightShadow_q <= '0;
      schedErr_q       <= 1'b0;
    end else begin
      keyLeftShadow_q  <= keyLeftShadow_d;
      keyRightShadow_q <= keyRightShadow_d;
      schedErr_q       <= schedErr_d;
    end
  end
`endif

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Testbench for des_key_sched_ctrl: directed steps with a subkey scoreboard
// fed from an independent DES key-schedule model.

module tb_des_key_sched_ctrl;

  localparam logic [27:0] KL       = 28'hF0CCAAF;
  localparam logic [27:0] KR       = 28'h556678F;
  localparam logic [47:0] K1_CONST  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_CONST = 48'hCB3D8B0E17F5;

  localparam int PC2_REF [48] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic [3:0]  round;
    logic [47:0] key;
  } exp_t;

  logic        CLK;
  logic        RESET_BAR;
  logic        START, DECRYPT, ABORT, SUBKEY_ACCEPT;
  logic [27:0] KEY_LEFT, KEY_RIGHT;
  logic [47:0] SUBKEY;
  logic        SUBKEY_VALID, BUSY, DONE;
  logic [3:0]  ROUND;

  logic        aStart;
  logic [47:0] aSubkey;
  logic        aValid, aBusy, aDone;
  logic [3:0]  aRound;
`ifdef DES_KEY_SCHED_CHECK_EN
  logic        SCHED_ERR, aSchedErr;
  logic [27:0] corrupt;
`endif

  exp_t        sbQ[$];
  logic [47:0] refKs [16];
  int          compared   = 0;
  int          mismatched = 0;
  int          hsCount    = 0;
  int          donePulses = 0;

  des_key_sched_ctrl #(.AUTO_ACCEPT(1'b0)) u_dut (
    .CLK(CLK), .RESET_BAR(RESET_BAR), .START(START), .DECRYPT(DECRYPT),
    .ABORT(ABORT), .KEY_LEFT(KEY_LEFT), .KEY_RIGHT(KEY_RIGHT),
    .SUBKEY_ACCEPT(SUBKEY_ACCEPT), .SUBKEY(SUBKEY), .SUBKEY_VALID(SUBKEY_VALID),
    .ROUND(ROUND), .BUSY(BUSY), .DONE(DONE)
`ifdef DES_KEY_SCHED_CHECK_EN
    , .SCHED_ERR(SCHED_ERR)
`endif
  );

  des_key_sched_ctrl #(.AUTO_ACCEPT(1'b1)) u_auto (
    .CLK(CLK), .RESET_BAR(RESET_BAR), .START(aStart), .DECRYPT(1'b0),
    .ABORT(1'b0), .KEY_LEFT(KL), .KEY_RIGHT(KR),
    .SUBKEY_ACCEPT(1'b0), .SUBKEY(aSubkey), .SUBKEY_VALID(aValid),
    .ROUND(aRound), .BUSY(aBusy), .DONE(aDone)
`ifdef DES_KEY_SCHED_CHECK_EN
    , .SCHED_ERR(aSchedErr)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic dec, input logic ab, input logic acc);
    START         = st;
    DECRYPT       = dec;
    ABORT         = ab;
    SUBKEY_ACCEPT = acc;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [47:0] pc2Ref(input logic [55:0] cdv);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) begin
      r = {r[46:0], cdv[6'(56 - PC2_REF[j])]};
    end
    return r;
  endfunction

  // Textbook schedule: cumulative left shifts, PC2 after each round
  task automatic buildSchedule(input logic [27:0] kl, input logic [27:0] kr);
    logic [27:0] c;
    logic [27:0] d;
    c = kl;
    d = kr;
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < SHIFTS[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      refKs[i] = pc2Ref({c, d});
    end
  endtask

  task automatic pushSchedule(input logic [27:0] kl, input logic [27:0] kr, input logic dec);
    exp_t e;
    buildSchedule(kl, kr);
    for (int r = 0; r < 16; r++) begin
      e.round = 4'(r);
      e.key   = dec ? refKs[15 - r] : refKs[r];
      sbQ.push_back(e);
    end
  endtask

  // Scoreboard monitor: every valid cycle must show the queue head; pop on handshake
  always @(negedge CLK) begin
    if (RESET_BAR && SUBKEY_VALID) begin
      if (sbQ.size() == 0) begin
        compared++;
        assert (sbQ.size() != 0) else begin
          mismatched++;
          $error("[TB] FAIL sb_unexpected: observed valid subkey %0h expected none", SUBKEY);
        end
      end else begin
        checkOutput("sb_subkey", 64'(SUBKEY), 64'(sbQ[0].key));
        checkOutput("sb_round", 64'(ROUND), 64'(sbQ[0].round));
        if (SUBKEY_ACCEPT) begin
          void'(sbQ.pop_front());
          hsCount++;
        end
      end
    end
    if (DONE) donePulses++;
  end

  initial begin
    int          doneCyc;
    int          hs0;
    int          d0;
    int          stall;
    int          found;
    logic        acc;
    logic [27:0] kl2;
    logic [27:0] kr2;

    RESET_BAR = 1'b0;
    aStart    = 1'b0;
    KEY_LEFT  = KL;
    KEY_RIGHT = KR;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("rst_valid", 64'(SUBKEY_VALID), 64'(0));
    checkOutput("rst_busy", 64'(BUSY), 64'(0));
    checkOutput("rst_done", 64'(DONE), 64'(0));
    checkOutput("rst_round", 64'(ROUND), 64'(0));
    checkOutput("rst_subkey", 64'(SUBKEY), 64'(0));
    #9;
    RESET_BAR = 1'b1;
    tick();

    $display("[TB] encrypt schedule, always accept");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    pushSchedule(KL, KR, 1'b0);
    doneCyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (cyc == 1) begin
        checkOutput("enc_first_valid", 64'(SUBKEY_VALID), 64'(1));
        checkOutput("enc_k1", 64'(SUBKEY), 64'(K1_CONST));
      end
      if (cyc == 16) begin
        checkOutput("enc_round15", 64'(ROUND), 64'(15));
        checkOutput("enc_k16", 64'(SUBKEY), 64'(K16_CONST));
      end
      if (DONE) begin
        doneCyc = cyc;
        break;
      end
    end
    checkOutput("enc_done_latency", 64'(doneCyc), 64'(17));
    checkOutput("enc_done_valid_low", 64'(SUBKEY_VALID), 64'(0));
    checkOutput("enc_sb_drained", 64'(sbQ.size()), 64'(0));
    tick();
    checkOutput("enc_idle", 64'(BUSY), 64'(0));

    $display("[TB] decrypt schedule, always accept");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    pushSchedule(KL, KR, 1'b1);
    doneCyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      if (cyc == 1) checkOutput("dec_k16_first", 64'(SUBKEY), 64'(K16_CONST));
      if (cyc == 16) checkOutput("dec_k1_last", 64'(SUBKEY), 64'(K1_CONST));
      if (DONE) begin
        doneCyc = cyc;
        break;
      end
    end
    checkOutput("dec_done_latency", 64'(doneCyc), 64'(17));
    checkOutput("dec_sb_drained", 64'(sbQ.size()), 64'(0));
    tick();

    $display("[TB] random backpressure with a stall at round 7");
    kl2 = 28'($urandom);
    kr2 = 28'($urandom);
    KEY_LEFT  = kl2;
    KEY_RIGHT = kr2;
    hs0 = hsCount;
    d0  = donePulses;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    pushSchedule(kl2, kr2, 1'b1);
    stall   = 5;
    doneCyc = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      tick();
      if (DONE) begin
        doneCyc = cyc;
        break;
      end
      if (SUBKEY_VALID && (ROUND == 4'd7) && (stall > 0)) begin
        acc = 1'b0;
        stall--;
      end else begin
        acc = 1'($urandom_range(0, 1));
      end
      applyStimulus(1'b0, 1'b1, 1'b0, acc);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_done_seen", 64'(doneCyc > 0), 64'(1));
    checkOutput("bp_stall_taken", 64'(stall), 64'(0));
    tick();
    checkOutput("bp_handshakes", 64'(hsCount - hs0), 64'(16));
    checkOutput("bp_done_pulses", 64'(donePulses - d0), 64'(1));

    $display("[TB] abort at round 4 then restart");
    KEY_LEFT  = KL;
    KEY_RIGHT = KR;
    d0 = donePulses;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    pushSchedule(KL, KR, 1'b0);
    found = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (SUBKEY_VALID && (ROUND == 4'd4)) begin
        found = 1;
        break;
      end
    end
    checkOutput("abort_reached_r4", 64'(found), 64'(1));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    sbQ.delete();
    #1;
    checkOutput("abort_valid_low", 64'(SUBKEY_VALID), 64'(0));
    tick();
    checkOutput("abort_start_ignored", 64'(BUSY), 64'(0));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    pushSchedule(KL, KR, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("restart_round0", 64'(ROUND), 64'(0));
    checkOutput("restart_k1", 64'(SUBKEY), 64'(K1_CONST));
    doneCyc = 0;
    for (int cyc = 2; cyc <= 40; cyc++) begin
      tick();
      if (DONE) begin
        doneCyc = cyc;
        break;
      end
    end
    checkOutput("restart_done_latency", 64'(doneCyc), 64'(17));
    tick();
    checkOutput("abort_done_pulses", 64'(donePulses - d0), 64'(1));

    $display("[TB] asynchronous reset mid-run");
    d0 = donePulses;
    KEY_LEFT  = kl2;
    KEY_RIGHT = kr2;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    pushSchedule(kl2, kr2, 1'b1);
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    end
    #2;
    RESET_BAR = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(SUBKEY_VALID), 64'(0));
    checkOutput("arst_busy", 64'(BUSY), 64'(0));
    checkOutput("arst_round", 64'(ROUND), 64'(0));
    checkOutput("arst_subkey", 64'(SUBKEY), 64'(0));
    sbQ.delete();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    RESET_BAR = 1'b1;
    KEY_LEFT  = KL;
    KEY_RIGHT = KR;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    pushSchedule(KL, KR, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("post_rst_k1", 64'(SUBKEY), 64'(K1_CONST));
    doneCyc = 0;
    for (int cyc = 2; cyc <= 40; cyc++) begin
      tick();
      if (DONE) begin
        doneCyc = cyc;
        break;
      end
    end
    checkOutput("post_rst_done_latency", 64'(doneCyc), 64'(17));
    tick();
    checkOutput("post_rst_done_pulses", 64'(donePulses - d0), 64'(1));

    $display("[TB] auto-accept instance");
    buildSchedule(KL, KR);
    aStart = 1'b1;
    tick();
    aStart = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput("auto_valid", 64'(aValid), 64'(1));
      checkOutput("auto_round", 64'(aRound), 64'(i));
      checkOutput("auto_subkey", 64'(aSubkey), 64'(refKs[i]));
      tick();
    end
    checkOutput("auto_done", 64'(aDone), 64'(1));
    checkOutput("auto_fin_valid", 64'(aValid), 64'(0));
    tick();
    checkOutput("auto_idle", 64'(aBusy), 64'(0));
`ifdef DES_KEY_SCHED_CHECK_EN
    checkOutput("auto_sched_err_clean", 64'(aSchedErr), 64'(0));
    aStart = 1'b1;
    tick();
    aStart = 1'b0;
    tick();
    tick();
    corrupt = u_auto.c_q ^ 28'h10;
    force u_auto.c_q = corrupt;
    tick();
    release u_auto.c_q;
    found = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (aDone) begin
        found = 1;
        break;
      end
    end
    checkOutput("auto_corrupt_done", 64'(found), 64'(1));
    tick();
    checkOutput("auto_sched_err_set", 64'(aSchedErr), 64'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/des_key_sched_ctrl.md
Name: des_key_sched_ctrl

Overview:
- Iterative DES round-key sequencer.
- Replaces the fully unrolled 16-way subkey fan-out with a single C/D rotation register and one Permuted_Choice2 instance, emitting one 48-bit subkey per round under a valid/accept handshake.
- Sits between the PC1 key-load logic (Key_Generation halves) and an iterative round datapath.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).

Parameters:
- AUTO_ACCEPT, 0: 1 = ignore SUBKEY_ACCEPT and advance one round per cycle while in RUN.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_BAR  in  1  asynchronous, active-low reset.
- START  in  1  request a new schedule; sampled only in IDLE.
- DECRYPT  in  1  0 = encrypt order, 1 = decrypt order; latched with START.
- ABORT  in  1  abandon the schedule in progress.
- KEY_LEFT  in  28  C0 half after PC1; bit 28 is the first key bit.
- KEY_RIGHT  in  28  D0 half after PC1.
- SUBKEY_ACCEPT  in  1  datapath consumes the current subkey.
- SUBKEY  out  48  PC2(C,D) of the current round.
- SUBKEY_VALID  out  1  SUBKEY and ROUND are valid.
- ROUND  out  4  datapath round index 0..15 (round r = ROUND+1).
- BUSY  out  1  state is not IDLE.
- DONE  out  1  one-cycle pulse after round 16 is accepted.

Behaviour:
- Reset (async, RESET_BAR=0): state IDLE; C, D = 0; ROUND=0; SUBKEY_VALID=0; BUSY=0; DONE=0; dir=0. SUBKEY = PC2(0,0) = 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1: latch DECRYPT into dir.
  - Encrypt: load C=rotl1(KEY_LEFT), D=rotl1(KEY_RIGHT).
  - Decrypt: load C=KEY_LEFT, D=KEY_RIGHT (K16 uses C0,D0).
  - ROUND=0; go to RUN. First SUBKEY_VALID is the cycle after START (latency 1).
- RUN:
  - SUBKEY_VALID=1.
  - SUBKEY is combinational PC2 of the C/D registers; it is held stable while SUBKEY_ACCEPT=0.
  - Handshake completes on the cycle where SUBKEY_VALID & (SUBKEY_ACCEPT | AUTO_ACCEPT).
  - On a completed handshake with ROUND<15: ROUND+1. Apply the next-round shift to C and D.
- Shift schedules, indexed by next round r=2..16:
  - Encrypt, left rotate: r=2,9,16 → 1 bit; all other r → 2 bits.
  - Decrypt, right rotate, applied going from round n to n+1: 1 bit for n+1 = 2, 9, 16; 2 bits for all other n+1.
  - This yields K15, K14, ..., K1.
- Rotation definitions:
  - rotl1(X) = {X[27:1],X[28]}; rotl2 applies it twice.
  - rotr1(X) = {X[1],X[28:2]}.
- Handshake at ROUND=15: go to FIN. No further shift is applied.
- FIN: DONE=1 for exactly this cycle; SUBKEY_VALID=0; then IDLE. C/D retain their final values (C0,D0 encrypt; rotr1 chain result decrypt).
- ABORT:
  - Priority over the handshake in RUN/FIN: next state IDLE, SUBKEY_VALID=0, no DONE.
  - ABORT in IDLE has no effect, and START is ignored in that cycle.
- START is ignored in RUN/FIN; a new START is accepted only in IDLE, i.e. the cycle after the FIN cycle.
- SUBKEY_ACCEPT while SUBKEY_VALID=0 is ignored.
- ROUND counter never wraps; it saturates by the FIN transition.
- Reset asserted mid-schedule: immediate return to reset values; no DONE pulse.

Optional Feature:
- Macro: DES_KEY_SCHED_CHECK_EN.
- When defined, adds output SCHED_ERR (1 bit).
  - On the FIN cycle, compare C/D against copies of KEY_LEFT/KEY_RIGHT latched at START.
  - Encrypt: C16,D16 must equal C0,D0 (28 total shifts). Decrypt: C/D must equal rotl1(C0,D0).
  - A mismatch sets SCHED_ERR, which is sticky until reset or the next accepted START.
- When undefined: no port, no shadow registers, identical functional timing.

Test Plan:
- Encrypt, key 133457799BBCDFF1 (KEY_LEFT=F0CCAAF, KEY_RIGHT=556678F), SUBKEY_ACCEPT=1 → SUBKEY=1B02EFFC7072 at ROUND=0, CB3D8B0E17F5 at ROUND=15, DONE pulse on cycle 17 after START.
- Decrypt, same key → ROUND=0 SUBKEY=CB3D8B0E17F5, ROUND=15 SUBKEY=1B02EFFC7072; all 16 subkeys equal the encrypt list reversed.
- Backpressure: SUBKEY_ACCEPT toggled randomly (including 5-cycle stall at ROUND=7) → SUBKEY/ROUND stable during stall; exactly 16 handshakes; one DONE.
- ABORT at ROUND=4, then START same cycle and next cycle → abort cycle START ignored; next-cycle START restarts at ROUND=0 with correct K1; no DONE from aborted run.
- RESET_BAR pulsed low mid-RUN (between clock edges) → outputs zero asynchronously; START after release produces a clean schedule.
- AUTO_ACCEPT=1, SUBKEY_ACCEPT=0, START with DES_KEY_SCHED_CHECK_EN → 16 consecutive valid cycles; SCHED_ERR=0; forcing C register bit corruption → SCHED_ERR=1 at FIN.
